// File: rtl/gnss_ahb_search_satellite.sv
// rtl/gnss_ahb_search_satellite.sv - AHB-Lite register window for the GNSS acquisition-search engine
module gnss_ahb_search_satellite #(
  parameter int SV_W   = 6,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [WORD_W-1:0] haddr,
  input  logic [2:0]        hsize,
  input  logic [WORD_W-1:0] hwdata,
  input  logic              hready,
  output logic [WORD_W-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp,
  input  logic              search_busy,
  input  logic [WORD_W-1:0] search_dop,
  input  logic [WORD_W-1:0] search_code,
  output logic              search_start,
  output logic [SV_W-1:0]   search_sv
);

  // Word indices (haddr[11:2]) of the register window.
  localparam logic [9:0] OFF_CTRL   = 10'h040;
  localparam logic [9:0] OFF_SV     = 10'h041;
  localparam logic [9:0] OFF_STATUS = 10'h042;
  localparam logic [9:0] OFF_DOP    = 10'h043;
  localparam logic [9:0] OFF_CODE   = 10'h044;

  logic [9:0]      addr_q, addr_d;
  logic            write_q, write_d;
  logic            valid_q, valid_d;
  logic [SV_W-1:0] sv_q, sv_d;
  logic            start_q, start_d;
  logic            accept;

  logic unused_ok;
  assign unused_ok = ^{hsize, haddr[WORD_W-1:12], haddr[1:0], hwdata[WORD_W-1:SV_W], htrans[0]};

  assign accept = hsel & hready & htrans[1];

  // Writes commit at the end of the data phase, so a pipelined read of SV
  // in the next data phase already sees the new value without forwarding.
  always_comb begin
    valid_d = accept;
    addr_d  = accept ? haddr[11:2] : addr_q;
    write_d = accept ? hwrite : write_q;
    sv_d    = sv_q;
    start_d = 1'b0;
    if (valid_q && write_q) begin
      if (addr_q == OFF_SV) begin
        sv_d = hwdata[SV_W-1:0];
      end
      if (addr_q == OFF_CTRL && hwdata[0] && !search_busy) begin
        start_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
      sv_q    <= '0;
      start_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      write_q <= write_d;
      valid_q <= valid_d;
      sv_q    <= sv_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    hrdata = '0;
    if (valid_q && !write_q) begin
      case (addr_q)
        OFF_SV:     hrdata = {{(WORD_W-SV_W){1'b0}}, sv_q};
        OFF_STATUS: hrdata = {{(WORD_W-1){1'b0}}, search_busy};
        OFF_DOP:    hrdata = search_dop;
        OFF_CODE:   hrdata = search_code;
        default:    hrdata = '0;
      endcase
    end
  end

  assign hreadyout    = 1'b1;
  assign hresp        = 1'b0;
  assign search_start = start_q;
  assign search_sv    = sv_q;

endmodule

// File: tb/tb_gnss_ahb_search_satellite.sv
// tb/tb_gnss_ahb_search_satellite.sv - directed and randomized bench for gnss_ahb_search_satellite
module tb_gnss_ahb_search_satellite;

  localparam int SV_W   = 6;
  localparam int WORD_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              hsel;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [WORD_W-1:0] haddr;
  logic [2:0]        hsize;
  logic [WORD_W-1:0] hwdata;
  logic              hready;
  logic [WORD_W-1:0] hrdata;
  logic              hreadyout;
  logic              hresp;
  logic              search_busy;
  logic [WORD_W-1:0] search_dop;
  logic [WORD_W-1:0] search_code;
  logic              search_start;
  logic [SV_W-1:0]   search_sv;

  gnss_ahb_search_satellite #(.SV_W(SV_W), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
    .haddr(haddr), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp),
    .search_busy(search_busy), .search_dop(search_dop), .search_code(search_code),
    .search_start(search_start), .search_sv(search_sv)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: the register contents and the transfer awaiting its data phase.
  logic [SV_W-1:0] m_sv = '0;
  logic            exp_start = 1'b0;
  logic            pend_v = 1'b0;
  logic            pend_w = 1'b0;
  logic [11:0]     pend_a = '0;
  logic [31:0]     obs_rd;
  logic            obs_start;

  localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10;
  localparam logic [31:0] BASE = 32'h2004_0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a & 12'hFFC)
      12'h104: return {{(32-SV_W){1'b0}}, m_sv};
      12'h108: return {31'b0, search_busy};
      12'h10C: return search_dop;
      12'h110: return search_code;
      default: return 32'h0;
    endcase
  endfunction

  // One bus cycle: new address phase plus hwdata for the pending data phase.
  task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic busy, input logic rdy, input logic r);
    logic [31:0] exp_rd;
    hsel = sel; htrans = trans; hwrite = wr; haddr = addr; hwdata = wdata;
    search_busy = busy; hready = rdy; rst = r; hsize = 3'($urandom_range(0, 2));
    #2;
    exp_rd = (pend_v && !pend_w) ? model_read(pend_a) : 32'h0;
    obs_rd = hrdata;
    obs_start = search_start;
    check("hrdata", hrdata, exp_rd);
    check("search_start", {31'b0, search_start}, {31'b0, exp_start});
    check("search_sv", {26'b0, search_sv}, {26'b0, m_sv});
    check("hreadyout_hresp", {30'b0, hreadyout, hresp}, 32'h2);
    exp_start = 1'b0;
    if (r) begin
      m_sv   = '0;
      pend_v = 1'b0;
    end else begin
      if (pend_v && pend_w) begin
        if ((pend_a & 12'hFFC) == 12'h104) m_sv = wdata[SV_W-1:0];
        if ((pend_a & 12'hFFC) == 12'h100 && wdata[0] && !busy) exp_start = 1'b1;
      end
      pend_v = sel && rdy && trans[1];
      pend_w = wr;
      pend_a = addr[11:0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] wdata, input logic busy);
    step(1'b0, IDLE, 1'b0, 32'h0, wdata, busy, 1'b1, 1'b0);
  endtask

  initial begin
    search_dop = 32'd0; search_code = 32'd0;
    step(1'b0, IDLE, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(1'b0, IDLE, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("reset_sv", {26'b0, search_sv}, 32'h0);

    // Reads after reset
    step(1'b1, NSEQ, 1'b0, BASE + 32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, NSEQ, 1'b0, BASE + 32'h104, 32'h0, 1'b0, 1'b1, 1'b0);
    check("rd_ctrl_reset", obs_rd, 32'h0);
    idle(32'h0, 1'b0);
    check("rd_sv_reset", obs_rd, 32'h0);

    // SV write then read, separated and back-to-back
    step(1'b1, NSEQ, 1'b1, BASE + 32'h104, 32'h0, 1'b0, 1'b1, 1'b0);
    idle(32'h11, 1'b0);
    step(1'b1, NSEQ, 1'b0, BASE + 32'h104, 32'h0, 1'b0, 1'b1, 1'b0);
    idle(32'h0, 1'b0);
    check("rd_sv_17", obs_rd, 32'h11);
    check("sv_out_17", {26'b0, search_sv}, 32'd17);
    step(1'b1, NSEQ, 1'b1, BASE + 32'h104, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, NSEQ, 1'b0, BASE + 32'h104, 32'h11, 1'b0, 1'b1, 1'b0);
    idle(32'h0, 1'b0);
    check("rd_sv_b2b", obs_rd, 32'h11);

    // Result registers
    search_dop = 32'd1234; search_code = 32'd5678;
    step(1'b1, NSEQ, 1'b0, BASE + 32'h10C, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, NSEQ, 1'b0, BASE + 32'h110, 32'h0, 1'b1, 1'b1, 1'b0);
    check("rd_dop", obs_rd, 32'h0000_04D2);
    step(1'b1, NSEQ, 1'b0, BASE + 32'h108, 32'h0, 1'b1, 1'b1, 1'b0);
    check("rd_code", obs_rd, 32'h0000_162E);
    idle(32'h0, 1'b1);
    check("rd_status", obs_rd, 32'h1);

    // Start pulse when idle, none when busy
    step(1'b1, NSEQ, 1'b1, BASE + 32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
    idle(32'h1, 1'b0);
    idle(32'h0, 1'b0);
    check("start_pulse", {31'b0, obs_start}, 32'h1);
    idle(32'h0, 1'b0);
    check("start_one_cycle", {31'b0, obs_start}, 32'h0);
    step(1'b1, NSEQ, 1'b1, BASE + 32'h100, 32'h0, 1'b1, 1'b1, 1'b0);
    idle(32'h1, 1'b1);
    idle(32'h0, 1'b1);
    check("start_busy", {31'b0, obs_start}, 32'h0);
    step(1'b1, NSEQ, 1'b0, BASE + 32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
    idle(32'h0, 1'b0);
    check("rd_ctrl", obs_rd, 32'h0);

    // Field truncation, read-only write, unmapped offset
    step(1'b1, NSEQ, 1'b1, BASE + 32'h104, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, NSEQ, 1'b0, BASE + 32'h104, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    step(1'b1, NSEQ, 1'b1, BASE + 32'h10C, 32'h0, 1'b0, 1'b1, 1'b0);
    check("rd_sv_trunc", obs_rd, 32'h0000_003F);
    step(1'b1, NSEQ, 1'b0, BASE + 32'h10C, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    step(1'b1, NSEQ, 1'b0, BASE + 32'h11C, 32'h0, 1'b0, 1'b1, 1'b0);
    check("rd_dop_after_wr", obs_rd, 32'd1234);
    idle(32'h0, 1'b0);
    check("rd_unmapped", obs_rd, 32'h0);

    // Reset in the data phase of SV and CTRL writes
    step(1'b1, NSEQ, 1'b1, BASE + 32'h104, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, IDLE, 1'b0, 32'h0, 32'h2A, 1'b0, 1'b1, 1'b1);
    step(1'b1, NSEQ, 1'b1, BASE + 32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
    check("sv_after_rst", {26'b0, search_sv}, 32'h0);
    step(1'b0, IDLE, 1'b0, 32'h0, 32'h1, 1'b0, 1'b1, 1'b1);
    idle(32'h0, 1'b0);
    check("no_start_after_rst", {31'b0, obs_start}, 32'h0);

    // Randomized pipelined traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [11:0] off;
      off = ($urandom_range(0, 7) == 0) ? 12'($urandom) : (12'h100 | 12'($urandom_range(0, 31)));
      search_dop  = $urandom;
      search_code = $urandom;
      step($urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom),
           {20'h20040, off}, ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
           1'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 59) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
